// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key expansion controller: fills a 44-word round-key memory one word
// per clock from a single word generator, with word and round-key read ports.

module current_word_gen_128 (
  input  logic [5:0]  i,
  input  logic [31:0] prev_word,
  input  logic [31:0] prev_period_word,
  output logic [31:0] current_word
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    return SBOX_TABLE[(11'd2047 - {x, 3'b000}) -: 8];
  endfunction

  logic [31:0] rot_s;
  logic [31:0] sub_s;
  logic [7:0]  rcon_s;

  // RotWord/SubWord/Rcon path on period boundaries, plain XOR chain otherwise
  always_comb begin
    rot_s = {prev_word[23:0], prev_word[31:24]};
    sub_s = {sub_byte(rot_s[31:24]), sub_byte(rot_s[23:16]),
             sub_byte(rot_s[15:8]),  sub_byte(rot_s[7:0])};
    case (i[5:2])
      4'd1:    rcon_s = 8'h01;
      4'd2:    rcon_s = 8'h02;
      4'd3:    rcon_s = 8'h04;
      4'd4:    rcon_s = 8'h08;
      4'd5:    rcon_s = 8'h10;
      4'd6:    rcon_s = 8'h20;
      4'd7:    rcon_s = 8'h40;
      4'd8:    rcon_s = 8'h80;
      4'd9:    rcon_s = 8'h1b;
      4'd10:   rcon_s = 8'h36;
      default: rcon_s = 8'h00;
    endcase
    if (i[1:0] == 2'b00) begin
      current_word = prev_period_word ^ sub_s ^ {rcon_s, 24'h000000};
    end else begin
      current_word = prev_period_word ^ prev_word;
    end
  end

endmodule

module aes_key_schedule_ctrl #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [5:0]   rd_addr,
  output logic [31:0]  rd_word,
  input  logic [3:0]   round_sel,
  output logic [127:0] round_key
);

  localparam int NW = 4 * (NR + 1);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t      state_r;
  logic [5:0]  idx_r;
  logic [31:0] mem_r [0:NW-1];
  logic [5:0]  gen_idx_s;
  logic [31:0] gen_word_s;
  logic [5:0]  rk_base_s;

  // Outside EXPAND idx may sit at 0 or 44, so steer the generator to a safe index
  always_comb begin
    if (state_r == EXPAND) begin
      gen_idx_s = idx_r;
    end else begin
      gen_idx_s = 6'd4;
    end
  end

  current_word_gen_128 u_gen (
    .i                (gen_idx_s),
    .prev_word        (mem_r[gen_idx_s - 6'd1]),
    .prev_period_word (mem_r[gen_idx_s - 6'd4]),
    .current_word     (gen_word_s)
  );

  // Control FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= 6'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx_r     <= 6'd4;
            busy      <= 1'b1;
            key_valid <= 1'b0;
            state_r   <= EXPAND;
          end
        end
        EXPAND: begin
          idx_r <= idx_r + 6'd1;
          if (idx_r == 6'(NW - 1)) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            key_valid <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Round-key memory is deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && state_r == IDLE && start) begin
      for (int k = 0; k < NK; k++) begin
        mem_r[k] <= key_in[127 - 32*k -: 32];
      end
    end else if (!rst && state_r == EXPAND) begin
      mem_r[idx_r] <= gen_word_s;
    end
  end

  // Registered word read port; out-of-range addresses read as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_word <= 32'h0;
    end else if (rd_addr <= 6'(NW - 1)) begin
      rd_word <= mem_r[rd_addr];
    end else begin
      rd_word <= 32'h0;
    end
  end

  // Combinational round-key view
  always_comb begin
    if (round_sel <= 4'(NR)) begin
      rk_base_s = {round_sel, 2'b00};
      round_key = {mem_r[rk_base_s], mem_r[rk_base_s + 6'd1],
                   mem_r[rk_base_s + 6'd2], mem_r[rk_base_s + 6'd3]};
    end else begin
      rk_base_s = 6'd0;
      round_key = 128'h0;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Directed bench for aes_key_schedule_ctrl using FIPS-197 and all-zero keys.

module tb_aes_key_schedule_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [5:0]   rd_addr;
  logic [31:0]  rd_word;
  logic [3:0]   round_sel;
  logic [127:0] round_key;

  int checks;
  int fails;

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY0 = 128'h0;

  aes_key_schedule_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rd_addr   (rd_addr),
    .rd_word   (rd_word),
    .round_sel (round_sel),
    .round_key (round_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   addr;
    logic [3:0]   rsel;
    logic [31:0]  exp_word;
    logic [127:0] exp_rk;
  } rd_vec_t;

  rd_vec_t vecs [0:9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for done; optionally pulse start with another key at cycle inject_at
  task automatic wait_done(input int inject_at, input logic [127:0] inj_key, output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == inject_at) begin
        start  = 1'b1;
        key_in = inj_key;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    start = 1'b0;
    if (!done) begin
      fails++;
      checks++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", n);
    end
  endtask

  task automatic kick(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) begin
      rd_addr   = vecs[v].addr;
      round_sel = vecs[v].rsel;
      #1;
      check($sformatf("round_key[%0d]", v), round_key, vecs[v].exp_rk);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rd_word[%0d]", v), {96'h0, rd_word}, {96'h0, vecs[v].exp_word});
    end
  endtask

  initial begin
    int n;
    int extra_done;
    checks = 0;
    fails  = 0;
    vecs[0] = '{6'd0,  4'd0,  32'h2b7e1516, KEY1};
    vecs[1] = '{6'd4,  4'd1,  32'ha0fafe17, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{6'd5,  4'd10, 32'h88542cb1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[3] = '{6'd43, 4'd11, 32'hb6630ca6, 128'h0};
    vecs[4] = '{6'd44, 4'd15, 32'h0,        128'h0};
    vecs[5] = '{6'd63, 4'd0,  32'h0,        KEY1};
    vecs[6] = '{6'd4,  4'd1,  32'h62636363, 128'h62636363626363636263636362636363};
    vecs[7] = '{6'd43, 4'd10, 32'h6f8f188e, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[8] = '{6'd3,  4'd0,  32'h0,        KEY0};
    vecs[9] = '{6'd40, 4'd11, 32'hb4ef5bcb, 128'h0};

    rst = 1'b1; start = 1'b0; key_in = 128'h0; rd_addr = 6'd0; round_sel = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {127'h0, busy}, 128'h0);
    check("reset_done", {127'h0, done}, 128'h0);
    check("reset_key_valid", {127'h0, key_valid}, 128'h0);
    check("reset_rd_word", {96'h0, rd_word}, 128'h0);
    rst = 1'b0;

    // FIPS-197 key: latency and contents
    kick(KEY1);
    check("busy_after_start", {127'h0, busy}, 128'h1);
    wait_done(0, KEY0, n);
    check("latency_key1", n, 40);
    check("key_valid_key1", {127'h0, key_valid}, 128'h1);
    @(posedge clk); @(negedge clk);
    check("done_one_cycle", {127'h0, done}, 128'h0);
    run_table(0, 5);

    // Zero key, with an ignored start carrying KEY1 ten cycles in
    kick(KEY0);
    wait_done(10, KEY1, n);
    check("latency_ignored_start", n, 40);
    extra_done = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) extra_done++;
    end
    check("single_done_pulse", extra_done, 0);
    run_table(6, 9);

    // Reset 20 cycles into an expansion
    kick(KEY1);
    repeat (19) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_mid_busy", {127'h0, busy}, 128'h0);
    check("rst_mid_key_valid", {127'h0, key_valid}, 128'h0);
    rst = 1'b0;

    kick(KEY1);
    wait_done(0, KEY0, n);
    check("latency_after_rst", n, 40);
    rd_addr = 6'd43;
    // Back-to-back start on the done cycle
    start  = 1'b1;
    key_in = KEY0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("w43_after_rst", {96'h0, rd_word}, 128'hb6630ca6);
    check("b2b_key_valid", {127'h0, key_valid}, 128'h0);
    check("b2b_busy", {127'h0, busy}, 128'h1);
    wait_done(0, KEY0, n);
    check("latency_b2b", n, 40);
    run_table(7, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
